nv_fifo_rwsp_80x65_ctrl: RTL and testbench

Valid/ready FIFO controller wrapping one nv_ram_rwsp_80x65 instance (80 entries x 65 bits, registered read address, output register gated by ore). It sits between a producer and consumer that both speak the valid/ready handshake. It generates all RAM write, read and ore controls, and presents the RAM's dout register directly as the FIFO head. Total capacity is 81: 80 RAM slots plus the dout register.

---
 rtl/nv_fifo_rwsp_80x65_ctrl.sv | 131 +++++++++++++
 tb/tb_nv_fifo_rwsp_80x65_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/nv_fifo_rwsp_80x65_ctrl.sv
// Valid/ready FIFO controller around an 80x65 registered-read RAM.
// The RAM dout register is the FIFO head, which gives a total capacity of 81 entries.
module nv_fifo_rwsp_80x65_ctrl (
  input  logic        nvdla_core_clk,
  input  logic        nvdla_core_rstn,
  input  logic        wr_pvld,
  output logic        wr_prdy,
  input  logic [64:0] wr_pd,
  output logic        rd_pvld,
  input  logic        rd_prdy,
  output logic [64:0] rd_pd,
  output logic [6:0]  fifo_cnt,
  output logic        fifo_idle,
  input  logic [31:0] pwrbus_ram_pd
);

  localparam int          DATA_W = 65;
  localparam logic [6:0]  LAST   = 7'd79;
  localparam logic [6:0]  FULL   = 7'd80;

  function automatic logic [6:0] adr_next(input logic [6:0] adr);
    return (adr == LAST) ? 7'd0 : adr + 7'd1;
  endfunction

  function automatic logic [6:0] cnt_next(input logic [6:0] cnt,
                                          input logic       inc,
                                          input logic       dec);
    logic [6:0] r;
    r = cnt;
    if (inc && !dec)
      r = cnt + 7'd1;
    else if (!inc && dec)
      r = cnt - 7'd1;
    return r;
  endfunction

  logic [6:0]        wr_adr;
  logic [6:0]        rd_adr;
  logic [6:0]        ram_used;
  logic [6:0]        rd_avail;
  logic              s1_vld;
  logic              s2_vld;
  logic              wr_accept;
  logic              pop;
  logic              ore;
  logic              re;
  logic [DATA_W-1:0] ram_dout;

  // Handshake and RAM control decode from registered state.
  assign wr_prdy   = (ram_used != FULL);
  assign wr_accept = wr_pvld & wr_prdy;
  assign rd_pvld   = s2_vld;
  assign pop       = s2_vld & rd_prdy;
  assign ore       = s1_vld & (~s2_vld | pop);
  assign re        = (rd_avail != 7'd0) & (~s1_vld | ore);
  assign rd_pd     = ram_dout;
  assign fifo_cnt  = ram_used + {6'd0, s2_vld};
  assign fifo_idle = (fifo_cnt == 7'd0);

  // State update; only control is reset, payload lives in the RAM.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      wr_adr   <= 7'd0;
      rd_adr   <= 7'd0;
      ram_used <= 7'd0;
      rd_avail <= 7'd0;
      s1_vld   <= 1'b0;
      s2_vld   <= 1'b0;
    end else begin
      if (wr_accept)
        wr_adr <= adr_next(wr_adr);
      if (re)
        rd_adr <= adr_next(rd_adr);
      ram_used <= cnt_next(ram_used, wr_accept, ore);
      rd_avail <= cnt_next(rd_avail, wr_accept, re);
      s1_vld   <= re  | (s1_vld & ~ore);
      s2_vld   <= ore | (s2_vld & ~pop);
    end
  end

  nv_ram_rwsp_80x65 u_ram (
    .clk           (nvdla_core_clk),
    .pwrbus_ram_pd (pwrbus_ram_pd),
    .ra            (rd_adr),
    .re            (re),
    .ore           (ore),
    .dout          (ram_dout),
    .wa            (wr_adr),
    .we            (wr_accept),
    .di            (wr_pd)
  );

endmodule

// 80x65 RAM with a registered read address and an ore-gated output register.
// A write and an ore capture of the same slot on one edge returns the old data.
module nv_ram_rwsp_80x65 (
  input  logic        clk,
  input  logic [31:0] pwrbus_ram_pd,
  input  logic [6:0]  ra,
  input  logic        re,
  input  logic        ore,
  output logic [64:0] dout,
  input  logic [6:0]  wa,
  input  logic        we,
  input  logic [64:0] di
);

  logic [64:0] mem [0:79];
  logic [6:0]  ra_p0;
  logic [64:0] dout_p1;
  logic        unused_pwr;

  assign unused_pwr = ^pwrbus_ram_pd;
  assign dout       = dout_p1;

  // Stage 0: write port and read-address capture.
  always_ff @(posedge clk) begin
    if (we)
      mem[wa] <= di;
    if (re)
      ra_p0 <= ra;
  end

  // Stage 1: output register, held while ore is low.
  always_ff @(posedge clk) begin
    if (ore)
      dout_p1 <= mem[ra_p0];
  end

endmodule

// File: tb/tb_nv_fifo_rwsp_80x65_ctrl.sv
// Bench for nv_fifo_rwsp_80x65_ctrl: queue model checked every cycle plus directed literal checks.
module tb_nv_fifo_rwsp_80x65_ctrl;

  logic        clk;
  logic        rst_n;
  logic        wr_pvld;
  logic        wr_prdy;
  logic [64:0] wr_pd;
  logic        rd_pvld;
  logic        rd_prdy;
  logic [64:0] rd_pd;
  logic [6:0]  fifo_cnt;
  logic        fifo_idle;
  logic [31:0] pwrbus_ram_pd;

  int n_pass  = 0;
  int n_total = 0;

  nv_fifo_rwsp_80x65_ctrl dut (
    .nvdla_core_clk  (clk),
    .nvdla_core_rstn (rst_n),
    .wr_pvld         (wr_pvld),
    .wr_prdy         (wr_prdy),
    .wr_pd           (wr_pd),
    .rd_pvld         (rd_pvld),
    .rd_prdy         (rd_prdy),
    .rd_pd           (rd_pd),
    .fifo_cnt        (fifo_cnt),
    .fifo_idle       (fifo_idle),
    .pwrbus_ram_pd   (pwrbus_ram_pd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
    n_total++;
    if (act === exp)
      n_pass++;
    else
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Model: an entry is held from accept until pop; it is visible at the head
  // once it is at the front and at least 3 cycles have passed since its accept.
  typedef struct {
    logic [64:0] d;
    int          c;
  } ent_t;

  ent_t        q[$];
  int          cyc = 0;
  logic        prev_hold = 1'b0;
  logic [64:0] prev_pd;

  always @(negedge clk) begin
    logic exp_v;
    int   held;
    cyc++;
    if (!rst_n) begin
      q.delete();
      prev_hold = 1'b0;
      chk("rst_rd_pvld", rd_pvld, 1'b0);
      chk("rst_fifo_cnt", fifo_cnt, 0);
      chk("rst_fifo_idle", fifo_idle, 1'b1);
      chk("rst_wr_prdy", wr_prdy, 1'b1);
    end else begin
      held  = q.size();
      exp_v = (held > 0) && (q[0].c + 3 <= cyc);
      chk("m_rd_pvld", rd_pvld, exp_v);
      chk("m_fifo_cnt", fifo_cnt, held);
      chk("m_fifo_idle", fifo_idle, held == 0);
      chk("m_wr_prdy", wr_prdy, (held - int'(exp_v)) != 80);
      if (exp_v)
        chk("m_rd_pd", rd_pd, q[0].d);
      if (prev_hold)
        chk("m_rd_pd_stable", rd_pd, prev_pd);
      if (rd_pvld && rd_prdy && q.size() > 0)
        void'(q.pop_front());
      if (wr_pvld && wr_prdy)
        q.push_back('{d: wr_pd, c: cyc});
      prev_hold = rd_pvld && !rd_prdy;
      prev_pd   = rd_pd;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One write with rd_prdy=1 into an empty FIFO; head appears exactly 3 cycles later.
  task automatic single_write(input logic [64:0] v);
    step();
    wr_pvld = 1'b1;
    wr_pd   = v;
    rd_prdy = 1'b1;
    @(negedge clk);
    chk("sw_accept_rdy", wr_prdy, 1'b1);
    step();
    wr_pvld = 1'b0;
    @(negedge clk);
    chk("sw_lat1", rd_pvld, 1'b0);
    @(negedge clk);
    chk("sw_lat2", rd_pvld, 1'b0);
    @(negedge clk);
    chk("sw_lat3_vld", rd_pvld, 1'b1);
    chk("sw_lat3_pd", rd_pd, v);
    @(negedge clk);
    chk("sw_after_cnt", fifo_cnt, 0);
    chk("sw_after_idle", fifo_idle, 1'b1);
    chk("sw_after_vld", rd_pvld, 1'b0);
  endtask

  task automatic fill81(input int base);
    int sent;
    sent = 0;
    rd_prdy = 1'b0;
    for (int i = 0; i < 400 && sent < 81; i++) begin
      step();
      wr_pvld = 1'b1;
      wr_pd   = 65'(base + sent);
      @(negedge clk);
      if (wr_prdy)
        sent++;
    end
    step();
    wr_pvld = 1'b0;
    chk("fill_sent", sent, 81);
    @(negedge clk);
    chk("fill_cnt", fifo_cnt, 81);
    chk("fill_wr_prdy", wr_prdy, 1'b0);
  endtask

  initial begin
    int got;
    int iters;
    int sent;
    logic acc;
    rst_n         = 1'b0;
    wr_pvld       = 1'b0;
    wr_pd         = '0;
    rd_prdy       = 1'b0;
    pwrbus_ram_pd = 32'h0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("init_wr_prdy", wr_prdy, 1'b1);
    chk("init_idle", fifo_idle, 1'b1);

    single_write(65'h1_2345_6789_ABCD_EF01);

    // Fill to 81 then drain back to back in order.
    fill81(0);
    step();
    rd_prdy = 1'b1;
    got = 0;
    iters = 0;
    for (int i = 0; i < 200 && got < 81; i++) begin
      @(negedge clk);
      iters++;
      if (rd_pvld && rd_prdy) begin
        chk("drain_order", rd_pd, 65'(got));
        got++;
      end
    end
    chk("drain_count", got, 81);
    chk("drain_cycles", iters, 81);
    @(negedge clk);
    chk("drain_empty", fifo_cnt, 0);

    // Full, single pop, write into the freed slot, drain.
    fill81(100);
    step();
    rd_prdy = 1'b1;
    @(negedge clk);
    chk("fp_pop_pd", rd_pd, 65'd100);
    step();
    rd_prdy = 1'b0;
    wr_pvld = 1'b1;
    wr_pd   = 65'd500;
    @(negedge clk);
    chk("fp_wr_prdy_rise", wr_prdy, 1'b1);
    step();
    wr_pvld = 1'b0;
    @(negedge clk);
    chk("fp_refull_cnt", fifo_cnt, 81);
    chk("fp_refull_prdy", wr_prdy, 1'b0);
    step();
    rd_prdy = 1'b1;
    got = 0;
    for (int i = 0; i < 200 && got < 81; i++) begin
      @(negedge clk);
      if (rd_pvld && rd_prdy) begin
        chk("fp_order", rd_pd, (got == 80) ? 65'd500 : 65'(101 + got));
        got++;
      end
    end
    chk("fp_count", got, 81);

    // Continuous stream of 200 with both sides always ready.
    step();
    sent = 0;
    got = 0;
    iters = 0;
    wr_pvld = 1'b1;
    wr_pd   = 65'd1000;
    rd_prdy = 1'b1;
    for (int i = 0; i < 400 && got < 200; i++) begin
      @(negedge clk);
      iters++;
      if (wr_pvld && wr_prdy)
        sent++;
      if (rd_pvld) begin
        chk("stream_order", rd_pd, 65'(1000 + got));
        got++;
      end
      step();
      wr_pvld = (sent < 200);
      wr_pd   = 65'(1000 + sent);
    end
    wr_pvld = 1'b0;
    chk("stream_count", got, 200);
    chk("stream_cycles", iters, 203);

    // Random valid/ready traffic; the model checks every cycle.
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      acc = wr_pvld && wr_prdy;
      step();
      if (!wr_pvld || acc) begin
        wr_pvld = ($urandom_range(0, 1) == 1);
        wr_pd   = {$urandom_range(0, 1), $urandom, $urandom};
      end
      rd_prdy = ($urandom_range(0, 1) == 1);
    end
    wr_pvld = 1'b0;
    rd_prdy = 1'b1;
    for (int i = 0; i < 200 && fifo_cnt != 0; i++)
      @(negedge clk);
    chk("rand_drained", fifo_cnt, 0);

    // Asynchronous reset with 40 entries held.
    rd_prdy = 1'b0;
    sent = 0;
    for (int i = 0; i < 100 && sent < 40; i++) begin
      step();
      wr_pvld = 1'b1;
      wr_pd   = 65'(2000 + sent);
      @(negedge clk);
      if (wr_prdy)
        sent++;
    end
    step();
    wr_pvld = 1'b0;
    @(negedge clk);
    chk("pre_rst_cnt", fifo_cnt, 40);
    chk("pre_rst_vld", rd_pvld, 1'b1);
    step();
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_vld", rd_pvld, 1'b0);
    chk("async_rst_cnt", fifo_cnt, 0);
    chk("async_rst_prdy", wr_prdy, 1'b1);
    @(negedge clk);
    #2 rst_n = 1'b1;
    single_write(65'h0_DEAD_BEEF_CAFE_F00D);
    repeat (3) @(negedge clk);
    chk("post_rst_idle", fifo_idle, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
